// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl
//
// Drains one tile's worth of output vectors from the corelet OFIFO into the
// partial-sum memory. For each vector it pops the OFIFO and then writes to
// PMEM. On a first pass the popped data is written directly. On later passes
// the stored partial sum is read back, added lane-wise to the popped data,
// and the sum is written to the same address. On a last pass, negative lanes
// are clamped to zero before the write.
//
// Optional feature macro: DRAIN_SAT_EN
//   When defined, accumulation adds saturate to the signed lane range.
//   When undefined, accumulation adds wrap modulo 2^psum_bw.
//   First-pass writes are unaffected either way.
//
// Ports:
//   i_clk, i_reset    clock; asynchronous active-high reset
//   i_start           begin one drain (sampled only while idle)
//   i_first_pass      write OFIFO data directly (latched at start)
//   i_last_pass       apply ReLU to written data (latched at start)
//   i_base_addr       PMEM address of vector 0 (latched at start)
//   i_ofifo_valid     OFIFO head is valid (first-word fall-through)
//   i_ofifo_out       OFIFO head vector, lane k at [k*psum_bw +: psum_bw]
//   o_ofifo_rd        pop the OFIFO head on this edge
//   o_pmem_rd/wr      PMEM read / write strobes
//   o_pmem_addr       PMEM address (always the current vector address)
//   o_pmem_din        PMEM write data
//   i_pmem_dout       PMEM read data, valid one cycle after o_pmem_rd
//   o_busy            high whenever not idle
//   o_done            one-cycle pulse at the end of a drain
module ofifo_drain_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int num_out = 8,
  parameter int addr_w  = 11
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_first_pass,
  input  logic                   i_last_pass,
  input  logic [addr_w-1:0]      i_base_addr,
  input  logic                   i_ofifo_valid,
  input  logic [col*psum_bw-1:0] i_ofifo_out,
  output logic                   o_ofifo_rd,
  output logic                   o_pmem_rd,
  output logic                   o_pmem_wr,
  output logic [addr_w-1:0]      o_pmem_addr,
  output logic [col*psum_bw-1:0] o_pmem_din,
  input  logic [col*psum_bw-1:0] i_pmem_dout,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int VEC_W = col * psum_bw;
  localparam int CNT_W = (num_out > 1) ? $clog2(num_out) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(num_out - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_RD,
    S_ACC,
    S_WR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_first;
  logic                r_last;
  logic [addr_w-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [VEC_W-1:0]    r_vec;
  logic [VEC_W-1:0]    r_sum;
  logic [VEC_W-1:0]    w_accSum;
  logic [VEC_W-1:0]    w_wrData;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes are pure state decodes so reset drops them in the same cycle.
  always_comb begin
    w_next     = r_state;
    o_ofifo_rd = 1'b0;
    o_pmem_rd  = 1'b0;
    o_pmem_wr  = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_POP;
      end
      S_POP: begin
        o_ofifo_rd = i_ofifo_valid;
        if (i_ofifo_valid) w_next = r_first ? S_WR : S_RD;
      end
      S_RD: begin
        o_pmem_rd = 1'b1;
        w_next    = S_ACC;
      end
      S_ACC: begin
        w_next = S_WR;
      end
      S_WR: begin
        o_pmem_wr = 1'b1;
        w_next    = (r_cnt == LAST_CNT) ? S_DONE : S_POP;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_first <= i_first_pass;
            r_last  <= i_last_pass;
            r_addr  <= i_base_addr;
            r_cnt   <= '0;
          end
        end
        S_POP: begin
          if (i_ofifo_valid) r_vec <= i_ofifo_out;
        end
        // pmem_dout is the data for the read issued in S_RD.
        S_ACC: begin
          r_sum <= w_accSum;
        end
        // Address wraps naturally at the top of PMEM.
        S_WR: begin
          r_addr <= r_addr + addr_w'(1);
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  localparam logic signed [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  for (genvar k = 0; k < col; k++) begin : g_lane
    logic signed [psum_bw-1:0] w_a;
    logic signed [psum_bw-1:0] w_b;
    logic signed [psum_bw-1:0] w_laneSum;
    logic signed [psum_bw-1:0] w_src;

    assign w_a = r_vec[k*psum_bw +: psum_bw];
    assign w_b = i_pmem_dout[k*psum_bw +: psum_bw];

`ifdef DRAIN_SAT_EN
    // One guard bit: overflow when the top two bits of the sum disagree.
    logic signed [psum_bw:0] w_full;
    assign w_full    = {w_a[psum_bw-1], w_a} + {w_b[psum_bw-1], w_b};
    assign w_laneSum = (w_full[psum_bw] != w_full[psum_bw-1])
                     ? (w_full[psum_bw] ? LANE_MIN : LANE_MAX)
                     : w_full[psum_bw-1:0];
`else
    assign w_laneSum = w_a + w_b;
`endif

    assign w_accSum[k*psum_bw +: psum_bw] = w_laneSum;

    // ReLU comes after saturation, on whichever source is being written.
    assign w_src = r_first ? r_vec[k*psum_bw +: psum_bw] : r_sum[k*psum_bw +: psum_bw];
    assign w_wrData[k*psum_bw +: psum_bw] = (r_last && w_src[psum_bw-1]) ? '0 : w_src;
  end

  assign o_pmem_addr = r_addr;
  assign o_pmem_din  = w_wrData;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Testbench for ofifo_drain_ctrl: a table of directed drains with hand-derived
// lane results, a set of random drains checked against a lane-arithmetic model,
// and a hand-written reset-during-accumulate sequence.
module tb_ofifo_drain_ctrl;

  localparam int COL  = 8;
  localparam int BW   = 16;
  localparam int NOUT = 8;
  localparam int AW   = 11;
  localparam int VW   = COL * BW;

  typedef logic [VW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          firstPass;
  logic          lastPass;
  logic [AW-1:0] baseAddr;
  logic          ofifoValid;
  vec_t          ofifoOut;
  logic          ofifoRd;
  logic          pmemRd;
  logic          pmemWr;
  logic [AW-1:0] pmemAddr;
  vec_t          pmemDin;
  vec_t          pmemDout;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ofifo_drain_ctrl #(.col(COL), .psum_bw(BW), .num_out(NOUT), .addr_w(AW)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_first_pass (firstPass),
    .i_last_pass  (lastPass),
    .i_base_addr  (baseAddr),
    .i_ofifo_valid(ofifoValid),
    .i_ofifo_out  (ofifoOut),
    .o_ofifo_rd   (ofifoRd),
    .o_pmem_rd    (pmemRd),
    .o_pmem_wr    (pmemWr),
    .o_pmem_addr  (pmemAddr),
    .o_pmem_din   (pmemDin),
    .i_pmem_dout  (pmemDout),
    .o_busy       (busy),
    .o_done       (done)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // First-word fall-through OFIFO: popBase marks the start of the current
  // load, popCount advances on each accepted pop.
  vec_t fifoMem [0:15];
  int   popCount = 0;
  int   popBase  = 0;
  int   fifoLen  = 0;
  int   headIdx;
  logic stall    = 1'b0;

  assign headIdx    = popCount - popBase;
  assign ofifoValid = (headIdx < fifoLen) && !stall;
  assign ofifoOut   = (headIdx >= 0 && headIdx < 16) ? fifoMem[headIdx] : '0;

  always @(posedge clk) if (ofifoRd) popCount <= popCount + 1;

  // PMEM with one-cycle read latency and a bench-side preload port.
  vec_t          mem [0:2047];
  logic          tbWr = 1'b0;
  logic [AW-1:0] tbAddr = '0;
  vec_t          tbData = '0;

  always @(posedge clk) begin
    if (pmemRd) pmemDout <= mem[pmemAddr];
    if (pmemWr) mem[pmemAddr] <= pmemDin;
    else if (tbWr) mem[tbAddr] <= tbData;
  end

  // Expected write stream for the drain in progress.
  vec_t          expWr   [NOUT];
  logic [AW-1:0] expAddr [NOUT];
  vec_t          oldV    [NOUT];

  typedef struct {
    string         name;
    bit            first;
    bit            last;
    logic [AW-1:0] base;
    int            oldLane;
    int            fifoLane;
    int            fifoStep;
    int            expLane;
    int            expStep;
    bit            expRelu;
    int            stallIdx;
    int            stallLen;
    int            expCycles;
  } vecRec_t;

  vecRec_t tbl [8];

  task automatic checkOutput(input string name, input vec_t act, input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane k gets v0 + k*step, optionally clamped at zero.
  function automatic vec_t packLanes(input int v0, input int step, input bit relu);
    vec_t v;
    int   x;
    v = '0;
    for (int k = 0; k < COL; k++) begin
      x = v0 + k * step;
      if (relu && x < 0) x = 0;
      v[k*BW +: BW] = x[BW-1:0];
    end
    return v;
  endfunction

  // Reference result for one vector, from plain signed integer arithmetic.
  function automatic vec_t modelVec(input bit first, input bit last, input vec_t f, input vec_t o);
    vec_t r;
    int   a;
    int   b;
    int   s;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      a = int'($signed(f[k*BW +: BW]));
      b = int'($signed(o[k*BW +: BW]));
      if (first) begin
        s = a;
      end else begin
        s = a + b;
`ifdef DRAIN_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`else
        s = ((s % 65536) + 65536) % 65536;
        if (s >= 32768) s = s - 65536;
`endif
      end
      if (last && s < 0) s = 0;
      r[k*BW +: BW] = s[BW-1:0];
    end
    return r;
  endfunction

  function automatic vec_t randLane();
    vec_t v;
    int   x;
    v = '0;
    for (int k = 0; k < COL; k++) begin
      case ($urandom % 4)
        0:       x = 32767;
        1:       x = -32768;
        default: x = int'($urandom);
      endcase
      v[k*BW +: BW] = x[BW-1:0];
    end
    return v;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input vec_t d);
    @(negedge clk);
    tbWr   = 1'b1;
    tbAddr = a;
    tbData = d;
    @(negedge clk);
    tbWr = 1'b0;
  endtask

  // Pulse start for one cycle, then scramble the latched inputs.
  task automatic applyStimulus(input bit first, input bit last, input logic [AW-1:0] base,
                               output int startCyc);
    @(negedge clk);
    firstPass = first;
    lastPass  = last;
    baseAddr  = base;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    firstPass = ~first;
    lastPass  = ~last;
    baseAddr  = ~base;
    startCyc  = cyc;
  endtask

  // Run one drain and check every write against expWr/expAddr.
  task automatic runDrain(input bit first, input bit last, input logic [AW-1:0] base,
                          input int stallIdx, input int stallLen, input int expCycles);
    int            startCyc;
    int            wrIdx;
    int            lastRdCyc;
    int            stallCnt;
    logic [AW-1:0] lastRdAddr;
    bit            doneSeen;
    wrIdx      = 0;
    lastRdCyc  = -100;
    lastRdAddr = '0;
    stallCnt   = 0;
    doneSeen   = 0;
    popBase    = popCount;
    fifoLen    = NOUT;
    applyStimulus(first, last, base, startCyc);
    checkOutput("busyAfterStart", VW'(busy), VW'(1));
    for (int t = 0; t < 400 && !doneSeen; t++) begin
      if (busy && !ofifoValid) checkOutput("noPopWhenEmpty", VW'(ofifoRd), VW'(0));
      if (pmemRd) begin
        lastRdCyc  = cyc;
        lastRdAddr = pmemAddr;
      end
      if (pmemWr) begin
        if (wrIdx < NOUT) begin
          checkOutput("wrAddr", VW'(pmemAddr), VW'(expAddr[wrIdx]));
          checkOutput("wrData", pmemDin, expWr[wrIdx]);
          if (!first) begin
            checkOutput("rdToWrGap", VW'(cyc - lastRdCyc), VW'(2));
            checkOutput("rdWrSameAddr", VW'(lastRdAddr), VW'(pmemAddr));
          end
        end else begin
          checkOutput("extraWrite", VW'(wrIdx + 1), VW'(NOUT));
        end
        wrIdx++;
        if (wrIdx == stallIdx && stallLen > 0) begin
          stall    = 1'b1;
          stallCnt = stallLen + 2;
        end
      end
      if (done) begin
        doneSeen = 1;
        checkOutput("doneCycle", VW'(cyc - startCyc), VW'(expCycles));
      end
      if (stallCnt > 0) begin
        stallCnt--;
        if (stallCnt == 0) stall = 1'b0;
      end
      if (!doneSeen) @(negedge clk);
    end
    stall = 1'b0;
    if (!doneSeen) checkOutput("doneTimeout", VW'(0), VW'(1));
    checkOutput("writeCount", VW'(wrIdx), VW'(NOUT));
    checkOutput("popCount", VW'(popCount - popBase), VW'(NOUT));
    @(negedge clk);
    checkOutput("idleAfterDone", VW'({busy, done}), VW'(0));
    for (int i = 0; i < NOUT; i++) checkOutput("memFinal", mem[expAddr[i]], expWr[i]);
  endtask

  initial begin
    int            startCyc;
    int            rdSeen;
    bit            first;
    bit            last;
    int            sIdx;
    int            sLen;
    logic [AW-1:0] base;

    tbl[0] = '{"firstPassRamp",   1, 0, 11'h010,    0,      1, 1,   1, 1, 0, 0, 0, 16};
    tbl[1] = '{"accumulate",      0, 0, 11'h040,  100,    -30, 0,  70, 0, 0, 0, 0, 32};
    tbl[2] = '{"reluNegative",    0, 1, 11'h060,    5,     -9, 0,   0, 0, 0, 0, 0, 32};
    tbl[3] = '{"reluPositive",    0, 1, 11'h070,    5,      9, 0,  14, 0, 0, 0, 0, 32};
`ifdef DRAIN_SAT_EN
    tbl[4] = '{"posOverflowWrap", 0, 0, 11'h7FE, 32767,     1, 0, 32767, 0, 0, 0, 0, 32};
    tbl[5] = '{"negOverflow",     0, 0, 11'h100, -32768,   -1, 0, -32768, 0, 0, 0, 0, 32};
`else
    tbl[4] = '{"posOverflowWrap", 0, 0, 11'h7FE, 32767,     1, 0, -32768, 0, 0, 0, 0, 32};
    tbl[5] = '{"negOverflow",     0, 0, 11'h100, -32768,   -1, 0, 32767, 0, 0, 0, 0, 32};
`endif
    tbl[6] = '{"firstLastRelu",   1, 1, 11'h120,  119,     -5, 3,  -5, 3, 1, 0, 0, 16};
    tbl[7] = '{"stallBeforeVec3", 0, 0, 11'h140,  100,    -30, 0,  70, 0, 0, 3, 5, 37};

    reset     = 1'b1;
    start     = 1'b0;
    firstPass = 1'b0;
    lastPass  = 1'b0;
    baseAddr  = '0;
    #1;
    checkOutput("rstOfifoRd", VW'(ofifoRd), VW'(0));
    checkOutput("rstPmemRd",  VW'(pmemRd),  VW'(0));
    checkOutput("rstPmemWr",  VW'(pmemWr),  VW'(0));
    checkOutput("rstAddr",    VW'(pmemAddr), VW'(0));
    checkOutput("rstDin",     pmemDin, '0);
    checkOutput("rstBusy",    VW'(busy), VW'(0));
    checkOutput("rstDone",    VW'(done), VW'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed table");
    for (int e = 0; e < 8; e++) begin
      for (int i = 0; i < NOUT; i++) begin
        fifoMem[i] = packLanes(tbl[e].fifoLane, tbl[e].fifoStep, 0);
        expAddr[i] = tbl[e].base + AW'(i);
        expWr[i]   = packLanes(tbl[e].expLane, tbl[e].expStep, tbl[e].expRelu);
        preload(expAddr[i], packLanes(tbl[e].oldLane, 0, 0));
      end
      $display("[TB] entry %s", tbl[e].name);
      runDrain(tbl[e].first, tbl[e].last, tbl[e].base, tbl[e].stallIdx, tbl[e].stallLen,
               tbl[e].expCycles);
    end

    $display("[TB] random drains");
    for (int it = 0; it < 10; it++) begin
      first = 1'($urandom % 2);
      last  = 1'($urandom % 2);
      base  = AW'($urandom);
      sIdx  = 0;
      sLen  = 0;
      if ($urandom % 3 == 0) begin
        sIdx = int'($urandom_range(1, NOUT - 1));
        sLen = int'($urandom_range(1, 4));
      end
      for (int i = 0; i < NOUT; i++) begin
        fifoMem[i] = randLane();
        oldV[i]    = randLane();
        expAddr[i] = base + AW'(i);
        expWr[i]   = modelVec(first, last, fifoMem[i], oldV[i]);
        preload(expAddr[i], oldV[i]);
      end
      runDrain(first, last, base, sIdx, sLen, NOUT * (first ? 2 : 4) + sLen);
    end

    $display("[TB] reset during accumulate");
    for (int i = 0; i < NOUT; i++) begin
      fifoMem[i] = packLanes(2, 0, 0);
      preload(11'h200 + AW'(i), packLanes(1, 0, 0));
    end
    popBase = popCount;
    fifoLen = NOUT;
    applyStimulus(0, 0, 11'h200, startCyc);
    rdSeen = 0;
    for (int t = 0; t < 100 && rdSeen < 2; t++) begin
      if (pmemRd) rdSeen++;
      if (rdSeen < 2) @(negedge clk);
    end
    checkOutput("secondReadSeen", VW'(rdSeen), VW'(2));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midRstBusy",  VW'(busy),    VW'(0));
    checkOutput("midRstWr",    VW'(pmemWr),  VW'(0));
    checkOutput("midRstRd",    VW'(pmemRd),  VW'(0));
    checkOutput("midRstPop",   VW'(ofifoRd), VW'(0));
    checkOutput("midRstAddr",  VW'(pmemAddr), VW'(0));
    checkOutput("midRstDin",   pmemDin, '0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checkOutput("noWriteInReset", VW'(pmemWr), VW'(0));
    end
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checkOutput("idleAfterReset", VW'({busy, pmemWr}), VW'(0));
    end
    checkOutput("vec0Written", mem[11'h200], packLanes(3, 0, 0));
    checkOutput("vec1Untouched", mem[11'h201], packLanes(1, 0, 0));

    for (int i = 0; i < NOUT; i++) begin
      fifoMem[i] = packLanes(-7 + i, 2, 0);
      oldV[i]    = randLane();
      expAddr[i] = 11'h300 + AW'(i);
      expWr[i]   = modelVec(0, 1, fifoMem[i], oldV[i]);
      preload(expAddr[i], oldV[i]);
    end
    runDrain(0, 1, 11'h300, 0, 0, NOUT * 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ofifo_drain_ctrl.md
# ofifo_drain_ctrl

Sequences the drain of the output FIFO (OFIFO) into the partial-sum memory (PMEM) after each tile is executed. Per output vector it pops the OFIFO, optionally reads back the stored partial sum, adds lane-wise, optionally applies ReLU, and writes the result back. It sits between the corelet OFIFO and the PMEM port and runs once per tile, after the array controller finishes execution.

## Interface
Parameters:
- col, 8, number of lanes per output vector
- psum_bw, 16, signed two's-complement width per lane
- num_out, 8, vectors drained per start
- addr_w, 11, PMEM address width

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- start  in  1  begin one drain; sampled only in S_IDLE
- first_pass  in  1  no accumulation: write OFIFO data directly; latched at start
- last_pass  in  1  apply ReLU to written data; latched at start
- base_addr  in  addr_w  PMEM address of vector 0; latched at start
- ofifo_valid  in  1  OFIFO holds at least one vector; ofifo_out is valid while high (first-word fall-through)
- ofifo_out  in  col*psum_bw  OFIFO head vector; lane k is bits [k*psum_bw +: psum_bw]
- ofifo_rd  out  1  pop OFIFO head this edge
- pmem_rd  out  1  PMEM read strobe
- pmem_wr  out  1  PMEM write strobe
- pmem_addr  out  addr_w  PMEM address
- pmem_din  out  col*psum_bw  PMEM write data
- pmem_dout  in  col*psum_bw  PMEM read data, valid one cycle after pmem_rd
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle pulse at end of drain

## Operation
- State machine: S_IDLE, S_POP, S_RD, S_ACC, S_WR, S_DONE.
- S_IDLE: when start=1, latch first_pass, last_pass, and base_addr into addr_q. Clear cnt. Go to S_POP. start is ignored in all other states.
- S_POP: ofifo_rd = ofifo_valid (combinational). On the edge with ofifo_rd=1, vec_q <= ofifo_out. Next state is S_WR if first_pass, else S_RD. If ofifo_valid=0, stay in S_POP indefinitely.
- S_RD: pmem_rd=1 for one cycle. Next state is S_ACC.
- S_ACC: sum_q <= lane-wise vec_q + pmem_dout, signed, psum_bw per lane. Next state is S_WR.
- S_WR: pmem_wr=1 for one cycle.
  - pmem_din is vec_q if first_pass, else sum_q.
  - If last_pass, each negative lane is replaced by 0.
  - Then addr_q <= addr_q+1 and cnt <= cnt+1.
  - If cnt==num_out-1, next state is S_DONE; otherwise S_POP.
- S_DONE: done=1 for one cycle. Next state is S_IDLE.
- pmem_addr = addr_q at all times.
- ofifo_rd, pmem_rd, pmem_wr and done are decoded combinationally from state.
- Arithmetic: lanes are independent; no carry crosses lanes. Default overflow behaviour is wrap modulo 2^psum_bw.
- addr_q wraps modulo 2^addr_w. Crossing the top of PMEM is legal and continues at address 0.
- first_pass=1 and last_pass=1 together is legal: data is written directly with ReLU.
- Reset asserted mid-operation returns to S_IDLE immediately and asynchronously. All strobes drop in the same cycle. A partially drained tile is abandoned; no further PMEM write occurs.

## Timing
- Reset values: ofifo_rd=0, pmem_rd=0, pmem_wr=0, pmem_addr=0, pmem_din=0, busy=0, done=0. Internal vec_q, sum_q, addr_q and cnt are 0.
- Start is sampled at edge T. busy rises after T, and ofifo_rd may assert in cycle T+1.
- Throughput with ofifo_valid held high:
  - first_pass: 2 cycles per vector (S_POP, S_WR).
  - otherwise: 4 cycles per vector (S_POP, S_RD, S_ACC, S_WR).
- Total drain time with no stalls: num_out*2+1 cycles (first_pass) or num_out*4+1 cycles (otherwise), counted from the cycle after start to the end of the done cycle.
- PMEM read-to-write distance is exactly 2 cycles at the same address. There is no other PMEM access in between.
- ofifo_rd never asserts while ofifo_valid=0. At most one pop occurs per vector.

## Configuration
- Macro: DRAIN_SAT_EN.
- Defined: S_ACC lane adds saturate to the range [-2^(psum_bw-1), 2^(psum_bw-1)-1]. Saturation is applied before ReLU.
- Undefined: lane adds wrap modulo 2^psum_bw.
- The macro has no effect on first_pass writes.

## Test plan
- first_pass=1, base_addr=0x10, 8 vectors with lane k = k+1 → PMEM 0x10..0x17 hold those values; done asserts 17 cycles after start.
- first_pass=0 with PMEM preloaded to 100 per lane, OFIFO lanes = -30 → PMEM holds 70 per lane; pmem_rd precedes pmem_wr by exactly 2 cycles at the same address.
- last_pass=1, first_pass=0, PMEM = 5, OFIFO = -9 → written lane = 0; with OFIFO = +9 → written lane = 14.
- ofifo_valid deasserted for 5 cycles before vector 3 → FSM holds in S_POP, ofifo_rd stays 0, and all data is still correct; done is delayed by 5 cycles.
- psum_bw=16, PMEM = 32767, OFIFO = 1 → result is 32767 with DRAIN_SAT_EN defined, -32768 without. base_addr=0x7FE → writes go to 0x7FE, 0x7FF, 0x000, ...
- Reset asserted while in S_ACC → pmem_wr never asserts for that vector, busy=0 immediately, and a subsequent start completes normally.
